// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for mod_counter
//
// Purpose: boundary-mode selection and the load clamping function.
// Configuration macro: SAT_EN (defined = saturate at the count limits,
// undefined = wrap around).
// Ports: none (package).

package counter_pkg;

  typedef enum logic {
    BND_WRAP = 1'b0,
    BND_SAT  = 1'b1
  } bnd_mode_t;

`ifdef SAT_EN
  localparam bnd_mode_t BND_MODE = BND_SAT;
`else
  localparam bnd_mode_t BND_MODE = BND_WRAP;
`endif

  // Values above the top of the count range clamp to it.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control/status bundle of the modulo counter
//
// Purpose: groups the counter's control inputs and count/status outputs.
// Ports (signals):
//   en, up, clr, load, load_val : driven by master, consumed by the counter
//   out, tc, ovf                : driven by the counter
// Modports: master (user side), slave (counter side).

interface mod_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             ovf;

  modport master (
    output en, up, clr, load, load_val,
    input  out, tc, ovf
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output out, tc, ovf
  );

endinterface

// File: rtl/tick_div.sv
// rtl/tick_div.sv - enable prescaler producing one step per PRESCALE enabled cycles
//
// Purpose: phase counter 0..PRESCALE-1 that advances on enabled cycles only.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-low reset (phase -> 0)
//   en      : advance the phase this cycle
//   restart : return the phase to 0 and suppress any step this cycle
//   step    : high on the enabled cycle that completes a phase period

module tick_div #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_direct
      // No phase state: every enabled cycle is a step.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign step = en & ~restart;
    end else begin : g_phase
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          phase <= '0;
        end else if (restart) begin
          phase <= '0;
        end else if (en) begin
          phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
      end

      assign step = en & ~restart & (phase == LAST);
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised modulo up/down counter with prescaler and boundary pulse
//
// Purpose: count register over 0..MAX with clear > load > step priority,
// terminal-count flag and registered boundary-event pulse.
// Configuration macro: SAT_EN (through counter_pkg::BND_MODE) selects
// saturating instead of wrapping behaviour at the count limits.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : mod_counter_if.slave (en, up, clr, load, load_val in;
//          out, tc (combinational), ovf (registered) out)

module mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic          clk,
  input  logic          rst,
  mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic             ovf_q;
  logic             step;
  logic             restart;
  logic             tc;

  assign restart = bus.clr | bus.load;

  tick_div #(
    .PRESCALE (PRESCALE)
  ) u_tick_div (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .restart (restart),
    .step    (step)
  );

  // Terminal count depends on the live direction, so it is combinational.
  assign tc = bus.up ? (count == MAX_V) : (count == '0);

  assign load_clamped = WIDTH'(clamp_load(32'(bus.load_val), 32'(MAX)));

  always_comb begin
    step_val = count;
    if (bus.up) begin
      if (count == MAX_V) begin
        step_val = (BND_MODE == BND_SAT) ? MAX_V : '0;
      end else begin
        step_val = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        step_val = (BND_MODE == BND_SAT) ? '0 : MAX_V;
      end else begin
        step_val = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      if (bus.clr) begin
        count <= '0;
      end else if (bus.load) begin
        count <= load_clamped;
      end else if (step) begin
        count <= step_val;
        // A step taken at the boundary (wrapped or held) raises the pulse.
        ovf_q <= tc;
      end
    end
  end

  assign bus.out = count;
  assign bus.tc  = tc;
  assign bus.ovf = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter

module tb_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) bus_a ();
  mod_counter_if #(.WIDTH(4)) bus_b ();

  mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

`ifdef SAT_EN
  int t2_out[3] = '{0, 0, 0};
  int t2_ovf[3] = '{0, 1, 1};
  int t6_out[3] = '{9, 9, 9};
  int t6_ovf[3] = '{0, 1, 1};
  int dn0_out   = 0;
`else
  int t2_out[3] = '{0, 9, 8};
  int t2_ovf[3] = '{0, 1, 0};
  int t6_out[3] = '{9, 0, 1};
  int t6_ovf[3] = '{0, 1, 0};
  int dn0_out   = 9;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int exp_out;
    int exp_ovf;
    bus_a.en = 0; bus_a.up = 1; bus_a.clr = 0; bus_a.load = 0; bus_a.load_val = 0;
    bus_b.en = 0; bus_b.up = 1; bus_b.clr = 0; bus_b.load = 0; bus_b.load_val = 0;

    // Reset state, before any clock edge.
    #1;
    check("rst_out", 32'(bus_a.out), 0);
    check("rst_ovf", 32'(bus_a.ovf), 0);
    check("rst_tc_up", 32'(bus_a.tc), 0);
    bus_a.up = 0;
    #1;
    check("rst_tc_down", 32'(bus_a.tc), 1);
    bus_a.up = 1;
    tick;
    tick;
    check("rst_hold_out", 32'(bus_a.out), 0);

    // 1. Count up from reset for 12 cycles.
    rst = 1;
    bus_a.en = 1;
    bus_a.up = 1;
    for (int k = 0; k < 12; k++) begin
`ifdef SAT_EN
      exp_out = (k > 9) ? 9 : k;
      exp_ovf = (k >= 10) ? 1 : 0;
`else
      exp_out = k % 10;
      exp_ovf = (k == 10) ? 1 : 0;
`endif
      check($sformatf("up_out_%0d", k), 32'(bus_a.out), 32'(exp_out));
      check($sformatf("up_tc_%0d", k), 32'(bus_a.tc), (exp_out == 9) ? 1 : 0);
      check($sformatf("up_ovf_%0d", k), 32'(bus_a.ovf), 32'(exp_ovf));
      tick;
    end
    bus_a.en = 0;

    // 2. Load 1 then count down through 0.
    bus_a.load_val = 1;
    bus_a.load = 1;
    tick;
    bus_a.load = 0;
    check("dn_load_out", 32'(bus_a.out), 1);
    check("dn_load_ovf", 32'(bus_a.ovf), 0);
    bus_a.up = 0;
    bus_a.en = 1;
    #1;
    check("dn_tc_at1", 32'(bus_a.tc), 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("dn_out_%0d", k), 32'(bus_a.out), 32'(t2_out[k]));
      check($sformatf("dn_ovf_%0d", k), 32'(bus_a.ovf), 32'(t2_ovf[k]));
    end
    bus_a.en = 0;

    // 6. Up from 8 for 3 steps, then down from 0 (boundary mode dependent).
    bus_a.up = 1;
    bus_a.load_val = 8;
    bus_a.load = 1;
    tick;
    bus_a.load = 0;
    check("b8_load_out", 32'(bus_a.out), 8);
    bus_a.en = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check($sformatf("b8_out_%0d", k), 32'(bus_a.out), 32'(t6_out[k]));
      check($sformatf("b8_ovf_%0d", k), 32'(bus_a.ovf), 32'(t6_ovf[k]));
    end
    bus_a.en = 0;
    bus_a.load_val = 0;
    bus_a.load = 1;
    tick;
    bus_a.load = 0;
    bus_a.up = 0;
    bus_a.en = 1;
    tick;
    check("b0_down_out", 32'(bus_a.out), 32'(dn0_out));
    check("b0_down_ovf", 32'(bus_a.ovf), 1);
    bus_a.en = 0;

    // 3. Load clamp and priority.
    bus_a.up = 1;
    bus_a.load_val = 12;
    bus_a.load = 1;
    tick;
    check("clamp_out", 32'(bus_a.out), 9);
    check("clamp_ovf", 32'(bus_a.ovf), 0);
    check("clamp_tc", 32'(bus_a.tc), 1);
    bus_a.clr = 1;
    bus_a.load_val = 5;
    tick;
    check("clr_over_load", 32'(bus_a.out), 0);
    bus_a.clr = 0;
    bus_a.load_val = 9;
    tick;
    check("load9_out", 32'(bus_a.out), 9);
    bus_a.en = 1;
    bus_a.load_val = 3;
    tick;
    check("load_over_step_out", 32'(bus_a.out), 3);
    check("load_over_step_ovf", 32'(bus_a.ovf), 0);
    bus_a.load = 0;
    bus_a.en = 0;

    // 4. Prescaler 3 with en toggling, then clr mid-phase.
    for (int c = 0; c < 12; c++) begin
      bus_b.en = (c % 2 == 0);
      tick;
      if (c == 3) check("ps_out_c3", 32'(bus_b.out), 0);
      if (c == 4) check("ps_out_c4", 32'(bus_b.out), 1);
    end
    check("ps_out_end", 32'(bus_b.out), 2);
    check("ps_ovf_end", 32'(bus_b.ovf), 0);
    bus_b.en = 1;
    tick;
    check("ps_phase1_out", 32'(bus_b.out), 2);
    bus_b.clr = 1;
    tick;
    bus_b.clr = 0;
    check("ps_clr_out", 32'(bus_b.out), 0);
    tick;
    tick;
    check("ps_after_clr_2", 32'(bus_b.out), 0);
    tick;
    check("ps_after_clr_3", 32'(bus_b.out), 1);
    bus_b.en = 0;

    // 5. Asynchronous reset mid-cycle with an ovf pulse pending.
    bus_a.up = 1;
    bus_a.load_val = 9;
    bus_a.load = 1;
    tick;
    bus_a.load = 0;
    bus_a.en = 1;
    tick;
    check("ar_ovf_pending", 32'(bus_a.ovf), 1);
    #2;
    rst = 0;
    #1;
    check("ar_out", 32'(bus_a.out), 0);
    check("ar_ovf", 32'(bus_a.ovf), 0);
    check("ar_tc", 32'(bus_a.tc), 0);
    check("ar_out_b", 32'(bus_b.out), 0);
    #1;
    rst = 1;
    tick;
    check("ar_resume_out", 32'(bus_a.out), 1);
    check("ar_resume_ovf", 32'(bus_a.ovf), 0);
    bus_a.en = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
